// File: rtl/sync_pkg.sv
// Shared types and defaults for the bus launcher.
// SYNC_BUS_LAUNCHER_ACK_EN adds the WAIT_ACK state to the state type.
package sync_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_EN_CYCLES  = 4;
    localparam int DEF_GAP_CYCLES = 4;

`ifdef SYNC_BUS_LAUNCHER_ACK_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_ACK = 2'd3
    } launch_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } launch_state_t;
`endif

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bus_launcher.sv
// Launches one word at a time onto an unsynchronized bus with a qualifying enable level.
// Build option SYNC_BUS_LAUNCHER_ACK_EN adds a bus_ack handshake from the destination.
module sync_bus_launcher
    import sync_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int EN_CYCLES  = DEF_EN_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef SYNC_BUS_LAUNCHER_ACK_EN
    input  logic                  bus_ack,
`endif
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] unsync_bus,
    output logic                  bus_enable,
    output logic                  busy
);

    localparam int CNT_W = $clog2(max2(EN_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    generate
        if (EN_CYCLES < 3 || GAP_CYCLES < 1 || DATA_WIDTH < 1) begin : g_param_check
            $error("sync_bus_launcher: need EN_CYCLES>=3, GAP_CYCLES>=1, DATA_WIDTH>=1");
        end
    endgenerate

    launch_state_t         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  en_q, en_d;

    // One counter serves both phases: loaded with the phase length minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_HOLD;
                    cnt_d   = EN_LOAD;
                    data_d  = in_data;
                    en_d    = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef SYNC_BUS_LAUNCHER_ACK_EN
                end else if (bus_ack) begin
                    state_d = ST_WAIT_ACK;
                    en_d    = 1'b0;
                end
`else
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    en_d    = 1'b0;
                end
`endif
            end
`ifdef SYNC_BUS_LAUNCHER_ACK_EN
            ST_WAIT_ACK: begin
                if (!bus_ack) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
`endif
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && !reset;
    assign busy       = (state_q != ST_IDLE);
    assign unsync_bus = data_q;
    assign bus_enable = en_q;

endmodule

// File: tb/tb_sync_bus_launcher.sv
// Self-checking bench: directed scenarios plus random traffic against a
// remaining-time reference model; a second instance checks the short-period configuration.
module tb_sync_bus_launcher;

    localparam int DW  = 8;
    localparam int EN  = 4;
    localparam int GAP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] unsync_bus;
    logic          bus_enable;
    logic          busy;

    logic          reset2;
    logic          in_valid2;
    logic [DW-1:0] in_data2;
    logic          in_ready2;
    logic [DW-1:0] unsync_bus2;
    logic          bus_enable2;
    logic          busy2;

    always #5 clk = ~clk;

    sync_bus_launcher #(.DATA_WIDTH(DW), .EN_CYCLES(EN), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .busy(busy)
    );

    sync_bus_launcher #(.DATA_WIDTH(DW), .EN_CYCLES(3), .GAP_CYCLES(1)) dut_short (
        .clk(clk), .reset(reset2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .unsync_bus(unsync_bus2), .bus_enable(bus_enable2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: captured word plus cycles left with enable high / busy.
    logic [DW-1:0] m_word;
    int            m_en_left;
    int            m_busy_left;
    int            acc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_word      = '0;
            m_en_left   = 0;
            m_busy_left = 0;
        end else if (in_valid && m_busy_left == 0) begin
            m_word      = in_data;
            m_en_left   = EN;
            m_busy_left = EN + GAP;
            acc_q.push_back(cyc);
            $display("accept data=0x%02h at cycle %0d", in_data, cyc);
        end else begin
            if (m_en_left > 0)   m_en_left--;
            if (m_busy_left > 0) m_busy_left--;
        end
        cyc++;
        #1;
        chk("in_ready",   32'(in_ready),   32'(m_busy_left == 0 && !reset));
        chk("busy",       32'(busy),       32'(m_busy_left > 0));
        chk("bus_enable", 32'(bus_enable), 32'(m_en_left > 0));
        chk("unsync_bus", 32'(unsync_bus), 32'(m_word));
    endtask

    initial begin
        int n0;
        int first_ready;
        int en_count;
        int t_first;
        int acc2[$];

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        reset2    = 1'b1;
        in_valid2 = 1'b1;
        in_data2  = 8'h3C;
        m_word      = '0;
        m_en_left   = 0;
        m_busy_left = 0;

        // Reset for three cycles, then a single 0xA5 transfer.
        repeat (3) step();
        chk("ready_low_in_reset", 32'(in_ready), 32'(0));
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'(1));
        n0 = acc_q.size();
        first_ready = 0;
        en_count    = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) begin
                chk("a5_accept_first_edge", 32'(acc_q.size() - n0), 32'(1));
                in_valid = 1'b0;
            end
            if (bus_enable) en_count++;
            if (in_ready && first_ready == 0) first_ready = i;
        end
        chk("a5_enable_cycles", 32'(en_count), 32'(EN));
        chk("a5_ready_return", 32'(first_ready), 32'(EN + GAP + 1));

        // Back-to-back 0x11 then 0x22 with in_valid held.
        in_valid = 1'b1;
        in_data  = 8'h11;
        n0 = acc_q.size();
        for (int i = 0; i < 30 && acc_q.size() < n0 + 2; i++) begin
            step();
            if (acc_q.size() == n0 + 1) in_data = 8'h22;
        end
        chk("b2b_two_accepts", 32'(acc_q.size() - n0), 32'(2));
        if (acc_q.size() >= n0 + 2)
            chk("b2b_period", 32'(acc_q[n0 + 1] - acc_q[n0]), 32'(EN + GAP + 1));
        in_valid = 1'b0;

        // Data and valid toggling while busy must not disturb the bus.
        for (int i = 0; i < 12 && busy; i++) step();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        step();
        for (int i = 0; i < 10; i++) begin
            in_data  = DW'($urandom);
            in_valid = (i % 2) == 1;
            step();
        end
        in_valid = 1'b0;

        // Reset pulsed in the second HOLD cycle aborts the transfer.
        for (int i = 0; i < 12 && busy; i++) step();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("abort_enable_low", 32'(bus_enable), 32'(0));
        chk("abort_bus_zero",   32'(unsync_bus), 32'(0));
        reset = 1'b0;
        #1;
        chk("abort_ready_after_release", 32'(in_ready), 32'(1));
        step();

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = DW'($urandom);
            step();
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();

        // Short configuration: EN_CYCLES=3, GAP_CYCLES=1 gives a 5-cycle period.
        reset2 = 1'b0;
        #1;
        t_first = -1;
        for (int i = 0; i < 40 && acc2.size() < 3; i++) begin
            if (in_ready2) acc2.push_back(i);
            @(posedge clk);
            #1;
        end
        chk("short_accepts", 32'(acc2.size()), 32'(3));
        if (acc2.size() == 3) begin
            t_first = acc2[0];
            chk("short_first_accept", 32'(t_first), 32'(0));
            chk("short_period_1", 32'(acc2[1] - acc2[0]), 32'(5));
            chk("short_period_2", 32'(acc2[2] - acc2[1]), 32'(5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
